// File: rtl/video_stream_padder_if.sv
// Write-strobe plus data word bus used between the decoder, the padder and the video buffer.
interface video_stream_padder_if #(
  parameter int DATA_W = 8
) ();
  logic [DATA_W-1:0] data;
  logic              wr;

  modport master (output data, output wr);
  modport slave  (input  data, input  wr);
endinterface

// File: rtl/video_stream_padder.sv
// Forwards decoder writes to the video buffer and, on end-of-stream, appends a fixed
// run of pad words or enough pad words to bring the stream length to an ALIGN boundary.
module video_stream_padder #(
  parameter int                DATA_W  = 8,
  parameter logic [DATA_W-1:0] PAD_VAL = '0,
  parameter int                MODE    = 0,
  parameter int                PAD_LEN = 24,
  parameter int                ALIGN   = 32,
  parameter int                PAD_MIN = 0,
  parameter int                CNT_W   = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clk_en_i,
  input  logic                  stream_start_i,
  input  logic                  stream_end_i,
  video_stream_padder_if.slave  in_if,
  video_stream_padder_if.master out_if,
  output logic                  busy_o,
  output logic                  pad_done_o,
  output logic                  overflow_err_o
);

  typedef enum logic [1:0] {IDLE, PAD, DONE} state_e;

  localparam logic [CNT_W-1:0] ALIGN_MASK = CNT_W'(ALIGN - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] streamCnt_q, padCnt_q, padTotal_q;
  logic [CNT_W-1:0] cntFinal, alignRem, padTotalCalc;
  logic             padDone_q, overflow_q, padLast;

  // ALIGN is a power of two dividing 2^CNT_W, so the modulo is a mask and wrap is harmless.
  always_comb begin
    cntFinal = streamCnt_q + CNT_W'(in_if.wr);
    alignRem = (cntFinal + CNT_W'(PAD_MIN)) & ALIGN_MASK;
    if (MODE == 0) begin
      padTotalCalc = CNT_W'(PAD_LEN);
    end else begin
      padTotalCalc = CNT_W'(PAD_MIN) + ((CNT_W'(ALIGN) - alignRem) & ALIGN_MASK);
    end
  end

  assign padLast = (padCnt_q == padTotal_q - CNT_W'(1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else if (clk_en_i) begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (stream_start_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (stream_end_i) state_d = (padTotalCalc != '0) ? PAD : DONE;
        PAD:     if (padLast) state_d = DONE;
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    out_if.data = in_if.data;
    out_if.wr   = in_if.wr;
    busy_o      = (state_q == PAD);
    if (state_q == PAD) begin
      out_if.data = PAD_VAL;
      out_if.wr   = clk_en_i;
    end
  end

  // Counters, latched pad length and status flags; a write arriving while padding is dropped.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      streamCnt_q <= '0;
      padCnt_q    <= '0;
      padTotal_q  <= '0;
      padDone_q   <= 1'b0;
      overflow_q  <= 1'b0;
    end else if (clk_en_i) begin
      padDone_q <= (state_d == DONE) && (state_q != DONE);
      if (stream_start_i) begin
        streamCnt_q <= '0;
        padCnt_q    <= '0;
        overflow_q  <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (in_if.wr) streamCnt_q <= streamCnt_q + CNT_W'(1);
            if (stream_end_i) begin
              padTotal_q <= padTotalCalc;
              padCnt_q   <= '0;
            end
          end
          PAD: begin
            if (in_if.wr) overflow_q <= 1'b1;
            if (!padLast) padCnt_q <= padCnt_q + CNT_W'(1);
          end
          default: ;
        endcase
      end
    end
  end

  assign pad_done_o     = padDone_q;
  assign overflow_err_o = overflow_q;

endmodule

// File: tb/tb_video_stream_padder.sv
// Drives four differently configured padders with one shared stimulus and checks them
// every cycle against a word-counting model, plus hand-computed pad and pulse counts.
module tb_video_stream_padder;
  localparam int N = 4;
  localparam int         CFG_MODE  [N] = '{0, 1, 1, 0};
  localparam int         CFG_LEN   [N] = '{24, 24, 24, 6};
  localparam int         CFG_ALIGN [N] = '{32, 32, 16, 32};
  localparam int         CFG_MIN   [N] = '{0, 0, 4, 0};
  localparam logic [7:0] CFG_PADV  [N] = '{8'h00, 8'h00, 8'h3C, 8'hA5};

  logic clk = 1'b0;
  logic rstN, clkEn, streamStart, streamEnd;
  logic [N-1:0] busy, padDone, ovf, dwr;
  logic [7:0]   dout [N];
  logic [47:0]  gotVec;

  int nVectors = 0;
  int nMiscompares = 0;

  int mWords [N];
  int mRemain [N];
  int mTotal [N];
  bit mDone [N];
  bit mErr [N];
  bit mOver [N];

  int padW [N];
  int doneP [N];
  int busyC [N];
  int gapW [N];
  int sPad [N];
  int sDone [N];
  int sBusy [N];
  int sGap [N];

  string litName;
  int    litGot, litExp;
  bit    litReq = 1'b0;

  always #5 clk = ~clk;

  video_stream_padder_if #(.DATA_W(8)) inIf ();
  video_stream_padder_if #(.DATA_W(8)) outIf0 ();
  video_stream_padder_if #(.DATA_W(8)) outIf1 ();
  video_stream_padder_if #(.DATA_W(8)) outIf2 ();
  video_stream_padder_if #(.DATA_W(8)) outIf3 ();

  video_stream_padder #(.DATA_W(8), .PAD_VAL(8'h00), .MODE(0), .PAD_LEN(24)) dut0 (
    .clk_i(clk), .rst_ni(rstN), .clk_en_i(clkEn), .stream_start_i(streamStart),
    .stream_end_i(streamEnd), .in_if(inIf), .out_if(outIf0), .busy_o(busy[0]),
    .pad_done_o(padDone[0]), .overflow_err_o(ovf[0]));
  video_stream_padder #(.DATA_W(8), .PAD_VAL(8'h00), .MODE(1), .ALIGN(32), .PAD_MIN(0)) dut1 (
    .clk_i(clk), .rst_ni(rstN), .clk_en_i(clkEn), .stream_start_i(streamStart),
    .stream_end_i(streamEnd), .in_if(inIf), .out_if(outIf1), .busy_o(busy[1]),
    .pad_done_o(padDone[1]), .overflow_err_o(ovf[1]));
  video_stream_padder #(.DATA_W(8), .PAD_VAL(8'h3C), .MODE(1), .ALIGN(16), .PAD_MIN(4)) dut2 (
    .clk_i(clk), .rst_ni(rstN), .clk_en_i(clkEn), .stream_start_i(streamStart),
    .stream_end_i(streamEnd), .in_if(inIf), .out_if(outIf2), .busy_o(busy[2]),
    .pad_done_o(padDone[2]), .overflow_err_o(ovf[2]));
  video_stream_padder #(.DATA_W(8), .PAD_VAL(8'hA5), .MODE(0), .PAD_LEN(6)) dut3 (
    .clk_i(clk), .rst_ni(rstN), .clk_en_i(clkEn), .stream_start_i(streamStart),
    .stream_end_i(streamEnd), .in_if(inIf), .out_if(outIf3), .busy_o(busy[3]),
    .pad_done_o(padDone[3]), .overflow_err_o(ovf[3]));

  assign dwr     = {outIf3.wr, outIf2.wr, outIf1.wr, outIf0.wr};
  assign dout[0] = outIf0.data;
  assign dout[1] = outIf1.data;
  assign dout[2] = outIf2.data;
  assign dout[3] = outIf3.data;
  assign gotVec  = {dwr, busy, padDone, ovf, dout[3], dout[2], dout[1], dout[0]};

  function automatic int padTotal(int i, int words);
    if (CFG_MODE[i] == 0) return CFG_LEN[i];
    return CFG_MIN[i] + ((CFG_ALIGN[i] - ((words + CFG_MIN[i]) % CFG_ALIGN[i])) % CFG_ALIGN[i]);
  endfunction

  function automatic logic [47:0] expVec();
    logic [N-1:0] eWr, eBusy, eDone, eErr;
    logic [7:0]   eData [N];
    for (int i = 0; i < N; i++) begin
      eBusy[i] = (mRemain[i] > 0);
      eWr[i]   = eBusy[i] ? clkEn : inIf.wr;
      eData[i] = eBusy[i] ? CFG_PADV[i] : inIf.data;
      eDone[i] = mDone[i];
      eErr[i]  = mErr[i];
    end
    return {eWr, eBusy, eDone, eErr, eData[3], eData[2], eData[1], eData[0]};
  endfunction

  // Model: a stream is a word count, then a number of pad words still owed, then finished.
  always @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      for (int i = 0; i < N; i++) begin
        mWords[i] <= 0; mRemain[i] <= 0; mDone[i] <= 1'b0; mErr[i] <= 1'b0; mOver[i] <= 1'b0;
      end
    end else if (clkEn) begin
      for (int i = 0; i < N; i++) begin
        mDone[i] <= 1'b0;
        if (streamStart) begin
          mWords[i] <= 0; mRemain[i] <= 0; mOver[i] <= 1'b0; mErr[i] <= 1'b0;
        end else if (mRemain[i] > 0) begin
          if (inIf.wr) mErr[i] <= 1'b1;
          mRemain[i] <= mRemain[i] - 1;
          if (mRemain[i] == 1) begin
            mDone[i] <= 1'b1; mOver[i] <= 1'b1;
          end
        end else if (!mOver[i]) begin
          if (inIf.wr) mWords[i] <= mWords[i] + 1;
          if (streamEnd) begin
            mTotal[i]  <= padTotal(i, mWords[i] + int'(inIf.wr));
            mRemain[i] <= padTotal(i, mWords[i] + int'(inIf.wr));
            if (padTotal(i, mWords[i] + int'(inIf.wr)) == 0) begin
              mDone[i] <= 1'b1; mOver[i] <= 1'b1;
            end
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      padW[i]  <= padW[i]  + int'(busy[i] & dwr[i]);
      doneP[i] <= doneP[i] + int'(padDone[i]);
      busyC[i] <= busyC[i] + int'(busy[i]);
      gapW[i]  <= gapW[i]  + int'(busy[i] & dwr[i] & ~clkEn);
    end
  end

  always @(negedge clk) begin
    nVectors     <= nVectors + 1 + (litReq ? 1 : 0);
    nMiscompares <= nMiscompares + ((gotVec !== expVec()) ? 1 : 0)
                    + ((litReq && litGot != litExp) ? 1 : 0);
    if (gotVec !== expVec())
      $display("[TB] FAIL cycle_outputs @%0t: got %h expected %h", $time, gotVec, expVec());
    if (litReq && litGot != litExp)
      $display("[TB] FAIL %s: got %0d expected %0d", litName, litGot, litExp);
  end

  task automatic applyStimulus(input logic en, input logic st, input logic ed,
                               input logic wr, input logic [7:0] d);
    clkEn = en; streamStart = st; streamEnd = ed; inIf.wr = wr; inIf.data = d;
    @(posedge clk); #1;
    clkEn = 1'b1; streamStart = 1'b0; streamEnd = 1'b0; inIf.wr = 1'b0;
  endtask

  task automatic checkOutput(input string name, input int got, input int exp);
    litName = name; litGot = got; litExp = exp; litReq = 1'b1;
    @(negedge clk); #1;
    litReq = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    for (int k = 0; k < n; k++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic writeWords(input int n, input bit endOnLast);
    for (int k = 0; k < n; k++)
      applyStimulus(1'b1, 1'b0, endOnLast && (k == n - 1), 1'b1, 8'(k + 1));
  endtask

  task automatic snap();
    for (int i = 0; i < N; i++) begin
      sPad[i] = padW[i]; sDone[i] = doneP[i]; sBusy[i] = busyC[i]; sGap[i] = gapW[i];
    end
  endtask

  initial begin
    rstN = 1'b0; clkEn = 1'b1; streamStart = 1'b0; streamEnd = 1'b0;
    inIf.wr = 1'b0; inIf.data = 8'h00;
    idleCycles(2);
    checkOutput("reset_flags", int'({busy, padDone, ovf}), 0);
    rstN = 1'b1;
    idleCycles(2);

    // Fixed 24 after five words, then pass-through in the finished state.
    snap(); applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    writeWords(5, 1'b0); applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 8'h00); idleCycles(40);
    checkOutput("fixed24_pads", padW[0] - sPad[0], 24);
    checkOutput("fixed24_busy_cycles", busyC[0] - sBusy[0], 24);
    checkOutput("fixed24_done_pulses", doneP[0] - sDone[0], 1);
    checkOutput("fixed6_pads", padW[3] - sPad[3], 6);
    inIf.data = 8'h77; inIf.wr = 1'b1; #1;
    checkOutput("done_passthru", int'({dwr[0], dout[0]}), 'h177);
    inIf.wr = 1'b0;

    // Align 32 after 40 words needs 24; align 16 min 4 after 40 needs 8.
    snap(); applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    writeWords(40, 1'b0); applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 8'h00); idleCycles(40);
    checkOutput("align32_40w_pads", padW[1] - sPad[1], 24);
    checkOutput("align16min4_40w_pads", padW[2] - sPad[2], 8);

    // 64 words already aligned: no pads, pulse on the very next cycle.
    snap(); applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    writeWords(64, 1'b0); applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
    checkOutput("align32_64w_done_next", int'({busy[1], padDone[1]}), 1);
    idleCycles(40);
    checkOutput("align32_64w_pads", padW[1] - sPad[1], 0);
    checkOutput("align32_64w_busy", busyC[1] - sBusy[1], 0);
    checkOutput("align32_64w_done_pulses", doneP[1] - sDone[1], 1);

    // stream_end on the 13th write: 13 counted, 19 pads.
    snap(); applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    writeWords(13, 1'b1); idleCycles(40);
    checkOutput("model_total_13w", mTotal[2], 19);
    checkOutput("align16min4_13w_pads", padW[2] - sPad[2], 19);

    // clk_en toggling while padding, plus one write dropped mid-pad.
    snap(); applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    writeWords(2, 1'b0); applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
    for (int k = 0; k < 12; k++) applyStimulus(k % 2 == 0, 1'b0, 1'b0, k == 2, 8'hEE);
    idleCycles(40);
    checkOutput("fixed6_toggle_pads", padW[3] - sPad[3], 6);
    checkOutput("pads_on_disabled_cycles",
                (gapW[0] - sGap[0]) + (gapW[1] - sGap[1]) + (gapW[2] - sGap[2]) + (gapW[3] - sGap[3]), 0);
    checkOutput("overflow_sticky", int'(ovf), 15);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    checkOutput("overflow_cleared", int'(ovf), 0);

    // Reset in the middle of a 24-word pad run, then a fresh run.
    snap(); applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
    idleCycles(10);
    #2 rstN = 1'b0;
    #1 checkOutput("busy_in_reset", int'(busy), 0);
    @(posedge clk); #1 rstN = 1'b1;
    checkOutput("pads_before_reset", padW[0] - sPad[0], 10);
    checkOutput("no_done_after_reset", doneP[0] - sDone[0], 0);
    snap(); applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 8'h00); idleCycles(40);
    checkOutput("fixed24_after_reset_pads", padW[0] - sPad[0], 24);
    checkOutput("fixed24_after_reset_done", doneP[0] - sDone[0], 1);

    // Writes in the finished state are not counted; re-arm then 32 words.
    writeWords(5, 1'b0);
    snap(); applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    writeWords(32, 1'b0); applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 8'h00); idleCycles(40);
    checkOutput("rearm_32w_pads_done", int'({8'(padW[1] - sPad[1]), 8'(doneP[1] - sDone[1])}), 1);
    checkOutput("rearm_align16_pads", padW[2] - sPad[2], 16);

    // stream_start together with stream_end: re-arm wins, nothing is padded.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    writeWords(3, 1'b0);
    snap(); applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 8'h00); idleCycles(10);
    checkOutput("start_wins_busy",
                (busyC[0] - sBusy[0]) + (busyC[1] - sBusy[1]) + (busyC[2] - sBusy[2]) + (busyC[3] - sBusy[3]), 0);
    checkOutput("start_wins_done",
                (doneP[0] - sDone[0]) + (doneP[1] - sDone[1]) + (doneP[2] - sDone[2]) + (doneP[3] - sDone[3]), 0);
    snap(); applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 8'h00); idleCycles(40);
    checkOutput("after_start_count_cleared", padW[1] - sPad[1], 0);
    checkOutput("after_start_fixed24", padW[0] - sPad[0], 24);

    idleCycles(2);
    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
